// File: rtl/maoin_ram_pkg.sv
// Shared types and constants for the on-chip RAM arbiter.
package maoin_ram_pkg;

    localparam int RAM_AW    = 15;
    localparam int RAM_DW    = 32;
    localparam int RAM_DEPTH = 25000;

    // Arbitration state: open round-robin, or a burst locked to one port.
    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

    // True when a word address falls inside the populated part of the RAM.
    function automatic logic addr_in_range(input logic [RAM_AW-1:0] addr,
                                           input logic [31:0]       depth);
        return ({{(32-RAM_AW){1'b0}}, addr} < depth);
    endfunction

endpackage

// File: rtl/maoin_rr_grant.sv
// Two-way round-robin grant with bounded lock bursts.
// Grants are combinational from the current requests and registered state,
// so a port learns it was accepted in the same cycle it asks.
module maoin_rr_grant
    import maoin_ram_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [1:0] req_i,
    input  logic [1:0] lock_i,
    output logic [1:0] gnt_o
);

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    arb_state_e state_q, state_d;
    logic       last_q, last_d;
    logic [7:0] hold_q, hold_d;
    logic [1:0] gnt_s;
    logic       own_s;

    // Port that owns the current lock burst (only meaningful in LOCK0/LOCK1).
    assign own_s = (state_q == LOCK1);

    // Nobody is accepted while reset is held.
    assign gnt_o = gnt_s & {2{~reset_i}};

    // Next-state, grant, last-winner pointer and burst length.
    always_comb begin
        gnt_s   = 2'b00;
        state_d = state_q;
        last_d  = last_q;
        hold_d  = hold_q;
        case (state_q)
            ARB: begin
                if (req_i[0] && req_i[1]) begin
                    // Tie goes to the port that did not win last.
                    gnt_s = last_q ? 2'b01 : 2'b10;
                end else begin
                    gnt_s = req_i;
                end
                if (gnt_s != 2'b00) begin
                    last_d = gnt_s[1];
                    // A one-grant limit means the lock would expire immediately.
                    if (lock_i[gnt_s[1]] && (HOLD_MAX > 8'd1)) begin
                        state_d = gnt_s[1] ? LOCK1 : LOCK0;
                        hold_d  = 8'd1;
                    end else begin
                        hold_d  = 8'd0;
                    end
                end else begin
                    last_d = last_q;
                end
            end
            LOCK0, LOCK1: begin
                if (req_i[own_s]) begin
                    gnt_s  = own_s ? 2'b10 : 2'b01;
                    hold_d = hold_q + 8'd1;
                    if (!lock_i[own_s] ||
                        (({1'b0, hold_q} + 9'd1) >= {1'b0, HOLD_MAX})) begin
                        state_d = ARB;
                        last_d  = own_s;
                        hold_d  = 8'd0;
                    end else begin
                        state_d = state_q;
                    end
                end else begin
                    // Owner went idle: release and let the other port win ties.
                    state_d = ARB;
                    last_d  = own_s;
                    hold_d  = 8'd0;
                end
            end
            default: begin
                state_d = ARB;
                last_d  = 1'b1;
                hold_d  = 8'd0;
            end
        endcase
    end

    // Arbitration state registers; port 0 wins the first tie after reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ARB;
            last_q  <= 1'b1;
            hold_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: rtl/maoin_ram_arbiter.sv
// Shares one single-port RAM between two Avalon-MM masters.
// Out-of-range accesses are accepted but never reach the RAM; they are
// counted, and reads among them return zero.
module maoin_ram_arbiter
    import maoin_ram_pkg::*;
#(
    parameter int DEPTH    = RAM_DEPTH,
    parameter int MAX_HOLD = 16,
    parameter int ERR_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [RAM_AW-1:0] s0_address,
    input  logic              s0_read,
    input  logic              s0_write,
    input  logic [3:0]        s0_byteenable,
    input  logic [RAM_DW-1:0] s0_writedata,
    input  logic              s0_lock,
    output logic              s0_waitrequest,
    output logic [RAM_DW-1:0] s0_readdata,
    output logic              s0_readdatavalid,
    input  logic [RAM_AW-1:0] s1_address,
    input  logic              s1_read,
    input  logic              s1_write,
    input  logic [3:0]        s1_byteenable,
    input  logic [RAM_DW-1:0] s1_writedata,
    input  logic              s1_lock,
    output logic              s1_waitrequest,
    output logic [RAM_DW-1:0] s1_readdata,
    output logic              s1_readdatavalid,
    output logic [RAM_AW-1:0] ram_address,
    output logic [3:0]        ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [RAM_DW-1:0] ram_writedata,
    output logic              ram_clken,
    input  logic [RAM_DW-1:0] ram_readdata,
    output logic [ERR_W-1:0]  err_count
);

    localparam logic [ERR_W-1:0] ERR_ONES = {ERR_W{1'b1}};

    logic [1:0]        req_s;
    logic [1:0]        gnt_s;
    logic              sel_s;
    logic              acc_s;
    logic              in_range_s;
    logic [RAM_AW-1:0] addr_sel_s;
    logic              wr_sel_s;
    logic [RAM_DW-1:0] rd_data_s;

    logic              rd_pend_q, rd_pend_d;
    logic              rd_port_q, rd_port_d;
    logic              rd_oor_q,  rd_oor_d;
    logic [ERR_W-1:0]  err_q,     err_d;

    assign req_s = {s1_read | s1_write, s0_read | s0_write};

    maoin_rr_grant #(
        .MAX_HOLD (MAX_HOLD)
    ) u_grant (
        .clk_i   (clk),
        .reset_i (reset),
        .req_i   (req_s),
        .lock_i  ({s1_lock, s0_lock}),
        .gnt_o   (gnt_s)
    );

    // Datapath follows the winning port (port 0 when nobody wins).
    assign sel_s      = gnt_s[1];
    assign acc_s      = gnt_s[0] | gnt_s[1];
    assign addr_sel_s = sel_s ? s1_address : s0_address;
    assign wr_sel_s   = sel_s ? s1_write   : s0_write;
    assign in_range_s = addr_in_range(addr_sel_s, 32'(DEPTH));

    assign s0_waitrequest = ~gnt_s[0];
    assign s1_waitrequest = ~gnt_s[1];

    assign ram_address    = addr_sel_s;
    assign ram_byteenable = sel_s ? s1_byteenable : s0_byteenable;
    assign ram_writedata  = sel_s ? s1_writedata  : s0_writedata;
    assign ram_chipselect = acc_s & in_range_s;
    assign ram_write      = acc_s & in_range_s & wr_sel_s;
    assign ram_clken      = 1'b1;

    // Read return: RAM data one cycle after accept, zero for rejected addresses.
    assign rd_data_s        = rd_oor_q ? {RAM_DW{1'b0}} : ram_readdata;
    assign s0_readdatavalid = rd_pend_q & ~rd_port_q;
    assign s1_readdatavalid = rd_pend_q &  rd_port_q;
    assign s0_readdata      = (rd_pend_q && !rd_port_q) ? rd_data_s : {RAM_DW{1'b0}};
    assign s1_readdata      = (rd_pend_q &&  rd_port_q) ? rd_data_s : {RAM_DW{1'b0}};
    assign err_count        = err_q;

    // Next read-return tag and saturating out-of-range counter.
    always_comb begin
        rd_pend_d = acc_s & ~wr_sel_s;
        rd_port_d = sel_s;
        rd_oor_d  = ~in_range_s;
        if (acc_s && !in_range_s && (err_q != ERR_ONES)) begin
            err_d = err_q + ERR_W'(1);
        end else begin
            err_d = err_q;
        end
    end

    // Read-return tag and error counter registers; reset drops any pending return.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend_q <= 1'b0;
            rd_port_q <= 1'b0;
            rd_oor_q  <= 1'b0;
            err_q     <= {ERR_W{1'b0}};
        end else begin
            rd_pend_q <= rd_pend_d;
            rd_port_q <= rd_port_d;
            rd_oor_q  <= rd_oor_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_maoin_ram_arbiter.sv
// Self-checking bench for maoin_ram_arbiter: directed scenarios plus random
// traffic, compared against a transaction-level model of the arbiter.
module tb_maoin_ram_arbiter;

    localparam int MAXH  = 4;
    localparam int DEPTH = 25000;

    logic        clk;
    logic        reset;
    logic [14:0] s0_address, s1_address;
    logic        s0_read, s0_write, s1_read, s1_write;
    logic [3:0]  s0_byteenable, s1_byteenable;
    logic [31:0] s0_writedata, s1_writedata;
    logic        s0_lock, s1_lock;
    logic        s0_waitrequest, s1_waitrequest;
    logic [31:0] s0_readdata, s1_readdata;
    logic        s0_readdatavalid, s1_readdatavalid;
    logic [14:0] ram_address;
    logic [3:0]  ram_byteenable;
    logic        ram_chipselect, ram_write, ram_clken;
    logic [31:0] ram_writedata;
    logic [31:0] ram_rd_q;
    logic [7:0]  err_count;

    maoin_ram_arbiter #(
        .DEPTH    (DEPTH),
        .MAX_HOLD (MAXH),
        .ERR_W    (8)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .s0_address       (s0_address),
        .s0_read          (s0_read),
        .s0_write         (s0_write),
        .s0_byteenable    (s0_byteenable),
        .s0_writedata     (s0_writedata),
        .s0_lock          (s0_lock),
        .s0_waitrequest   (s0_waitrequest),
        .s0_readdata      (s0_readdata),
        .s0_readdatavalid (s0_readdatavalid),
        .s1_address       (s1_address),
        .s1_read          (s1_read),
        .s1_write         (s1_write),
        .s1_byteenable    (s1_byteenable),
        .s1_writedata     (s1_writedata),
        .s1_lock          (s1_lock),
        .s1_waitrequest   (s1_waitrequest),
        .s1_readdata      (s1_readdata),
        .s1_readdatavalid (s1_readdatavalid),
        .ram_address      (ram_address),
        .ram_byteenable   (ram_byteenable),
        .ram_chipselect   (ram_chipselect),
        .ram_write        (ram_write),
        .ram_writedata    (ram_writedata),
        .ram_clken        (ram_clken),
        .ram_readdata     (ram_rd_q),
        .err_count        (err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Environment RAM: one-cycle read latency, byte-lane writes, cleared in reset.
    logic [31:0] env_mem [0:32767];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32768; i++) env_mem[i] <= 32'd0;
        end else if (ram_chipselect) begin
            if (ram_write) begin
                for (int b = 0; b < 4; b++)
                    if (ram_byteenable[b]) env_mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
            end else begin
                ram_rd_q <= env_mem[ram_address];
            end
        end
    end

    int n_checks;
    int n_pass;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Transaction-level reference model.
    logic [31:0] m_mem [0:32767];
    int          m_last;     // port that won the last open arbitration
    int          m_owner;    // port holding a lock burst, -1 if none
    int          m_streak;   // grants given in the current burst
    int          m_err;
    int          exp_port;   // port expecting readdatavalid now, -1 if none
    logic [31:0] exp_data;
    logic [1:0]  obs_gnt;

    function automatic int model_winner(input bit q0, input bit q1);
        if (m_owner >= 0) return ((m_owner == 0 ? q0 : q1) ? m_owner : -1);
        if (q0 && q1) return 1 - m_last;
        if (q0) return 0;
        if (q1) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        m_last = 1; m_owner = -1; m_streak = 0; m_err = 0; exp_port = -1; exp_data = 32'd0;
        for (int i = 0; i < 32768; i++) m_mem[i] = 32'd0;
    endtask

    task automatic idle();
        s0_read = 1'b0; s0_write = 1'b0; s0_lock = 1'b0; s0_address = 15'd0;
        s0_byteenable = 4'd0; s0_writedata = 32'd0;
        s1_read = 1'b0; s1_write = 1'b0; s1_lock = 1'b0; s1_address = 15'd0;
        s1_byteenable = 4'd0; s1_writedata = 32'd0;
    endtask

    task automatic set_port(input int p, input logic rd, input logic wr, input logic [14:0] a,
                            input logic [3:0] be, input logic [31:0] d, input logic lk);
        if (p == 0) begin
            s0_read = rd; s0_write = wr; s0_address = a; s0_byteenable = be; s0_writedata = d; s0_lock = lk;
        end else begin
            s1_read = rd; s1_write = wr; s1_address = a; s1_byteenable = be; s1_writedata = d; s1_lock = lk;
        end
    endtask

    // One clock cycle: entered 1 time unit after a rising edge with inputs set.
    task automatic step();
        int          w;
        bit          ww, inr, lk;
        logic [14:0] wa;
        logic [3:0]  be;
        logic [31:0] d;
        #1;
        w = model_winner(s0_read | s0_write, s1_read | s1_write);
        check_eq("rvalid0", s0_readdatavalid, exp_port == 0);
        check_eq("rvalid1", s1_readdatavalid, exp_port == 1);
        if (exp_port == 0) check_eq("rdata0", s0_readdata, exp_data);
        if (exp_port == 1) check_eq("rdata1", s1_readdata, exp_data);
        check_eq("waitreq0", s0_waitrequest, w != 0);
        check_eq("waitreq1", s1_waitrequest, w != 1);
        check_eq("err_count", err_count, m_err);
        obs_gnt = {~s1_waitrequest, ~s0_waitrequest};
        ww = 1'b0; inr = 1'b0; lk = 1'b0; wa = 15'd0; be = 4'd0; d = 32'd0;
        if (w >= 0) begin
            wa  = (w == 1) ? s1_address : s0_address;
            ww  = (w == 1) ? s1_write : s0_write;
            lk  = (w == 1) ? s1_lock : s0_lock;
            be  = (w == 1) ? s1_byteenable : s0_byteenable;
            d   = (w == 1) ? s1_writedata : s0_writedata;
            inr = (int'(wa) < DEPTH);
            check_eq("chipselect", ram_chipselect, inr);
            if (inr) begin
                check_eq("ram_address", ram_address, wa);
                check_eq("ram_write", ram_write, ww);
            end
        end else begin
            check_eq("chipselect_idle", ram_chipselect, 1'b0);
        end
        @(posedge clk);
        exp_port = -1;
        if (w >= 0) begin
            if (!inr && m_err < 255) m_err++;
            if (ww) begin
                if (inr)
                    for (int b = 0; b < 4; b++)
                        if (be[b]) m_mem[wa][8*b +: 8] = d[8*b +: 8];
            end else begin
                exp_port = w;
                exp_data = inr ? m_mem[wa] : 32'd0;
            end
        end
        if (m_owner >= 0) begin
            if (w < 0) begin
                m_last = m_owner; m_owner = -1;
            end else begin
                m_streak++;
                if (!lk || m_streak >= MAXH) begin m_last = m_owner; m_owner = -1; end
            end
        end else if (w >= 0) begin
            m_last = w;
            if (lk && MAXH > 1) begin m_owner = w; m_streak = 1; end
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_rvalid0", s0_readdatavalid, 1'b0);
        check_eq("rst_rvalid1", s1_readdatavalid, 1'b0);
        check_eq("rst_err", err_count, 8'd0);
        check_eq("rst_waitreq0", s0_waitrequest, 1'b1);
        check_eq("rst_waitreq1", s1_waitrequest, 1'b1);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        ram_rd_q = 32'd0;
        idle();
        model_reset();
        do_reset();

        // Continuous reads from both ports alternate, port 0 first.
        set_port(0, 1'b1, 1'b0, 15'd1, 4'hF, 32'd0, 1'b0);
        set_port(1, 1'b1, 1'b0, 15'd2, 4'hF, 32'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("alternate", obs_gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
        end

        // Write then read back through port 0.
        idle();
        set_port(0, 1'b0, 1'b1, 15'h0010, 4'hF, 32'hCAFEF00D, 1'b0);
        step();
        set_port(0, 1'b1, 1'b0, 15'h0010, 4'hF, 32'd0, 1'b0);
        step();
        check_eq("cafe_valid", s0_readdatavalid, 1'b1);
        check_eq("cafe_data", s0_readdata, 32'hCAFEF00D);

        // Partial byte-lane write.
        set_port(0, 1'b0, 1'b1, 15'h0020, 4'hF, 32'h12345678, 1'b0);
        step();
        set_port(0, 1'b0, 1'b1, 15'h0020, 4'h3, 32'hFFFFFFFF, 1'b0);
        step();
        set_port(0, 1'b1, 1'b0, 15'h0020, 4'hF, 32'd0, 1'b0);
        step();
        check_eq("byteenable", s0_readdata, 32'h1234FFFF);

        // Lock burst from port 1 is cut after MAXH grants.
        idle();
        set_port(0, 1'b1, 1'b0, 15'd3, 4'hF, 32'd0, 1'b0);
        step();
        set_port(1, 1'b1, 1'b0, 15'd4, 4'hF, 32'd0, 1'b1);
        for (int i = 0; i < MAXH + 1; i++) begin
            step();
            check_eq("lock_burst", obs_gnt, (i < MAXH) ? 2'b10 : 2'b01);
        end

        // Write from port 0 and read from port 1 at one address.
        idle();
        set_port(1, 1'b1, 1'b0, 15'd5, 4'hF, 32'd0, 1'b0);
        step();
        set_port(0, 1'b0, 1'b1, 15'h0030, 4'hF, 32'hA5A55A5A, 1'b0);
        set_port(1, 1'b1, 1'b0, 15'h0030, 4'hF, 32'd0, 1'b0);
        step();
        check_eq("collide_first", obs_gnt, 2'b01);
        step();
        check_eq("collide_second", obs_gnt, 2'b10);
        check_eq("collide_data", s1_readdata, 32'hA5A55A5A);

        // Out-of-range accesses.
        idle();
        set_port(0, 1'b1, 1'b0, 15'd25000, 4'hF, 32'd0, 1'b0);
        step();
        check_eq("oor_valid", s0_readdatavalid, 1'b1);
        check_eq("oor_data", s0_readdata, 32'd0);
        set_port(0, 1'b0, 1'b1, 15'h7FFF, 4'hF, 32'hDEADBEEF, 1'b0);
        step();
        check_eq("oor_err2", err_count, 8'd2);
        for (int i = 0; i < 298; i++) begin
            set_port(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     15'($urandom_range(25000, 32767)), 4'hF, $urandom, 1'b0);
            if (!s0_write) s0_read = 1'b1;
            step();
        end
        check_eq("oor_saturate", err_count, 8'd255);

        // Reset just after a read accept drops the return and the lock.
        idle();
        set_port(0, 1'b1, 1'b0, 15'h0010, 4'hF, 32'd0, 1'b1);
        step();
        reset = 1'b1;
        #1;
        check_eq("rst_async_rvalid", s0_readdatavalid, 1'b0);
        do_reset();
        set_port(0, 1'b1, 1'b0, 15'd6, 4'hF, 32'd0, 1'b0);
        set_port(1, 1'b1, 1'b0, 15'd7, 4'hF, 32'd0, 1'b0);
        step();
        check_eq("rst_tie", obs_gnt, 2'b01);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            for (int p = 0; p < 2; p++) begin
                int op;
                op = $urandom_range(0, 3);
                set_port(p, op == 1 || op == 3, op >= 2,
                         ($urandom_range(0, 15) == 0) ? 15'($urandom_range(25000, 32767))
                                                      : 15'($urandom_range(0, 7)),
                         4'($urandom_range(0, 15)), $urandom,
                         $urandom_range(0, 3) == 0);
            end
            step();
        end
        idle();
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/maoin_ram_arbiter.md
# maoin_ram_arbiter

Two-port arbiter sharing the single-port on-chip RAM (32-bit, 25000 words, 15-bit word address, one-cycle read latency) between two Avalon-MM masters, typically the CPU data master and a DMA/video engine. It grants at most one transfer per cycle using round-robin priority. It supports bounded lock bursts and returns read data with `readdatavalid` to the issuing port. It rejects out-of-range addresses and counts them.

## Interface
- `DEPTH`, 25000: valid word count; addresses >= DEPTH are out of range.
- `MAX_HOLD`, 16: maximum consecutive grants to a locking port (1..255).
- `ERR_W`, 8: width of the error counter.

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `sN_address`  in  15  word address (N = 0, 1).
- `sN_read`, `sN_write`  in  1  request strobes; both high is treated as write.
- `sN_byteenable`  in  4  byte lanes for writes.
- `sN_writedata`  in  32  write data.
- `sN_lock`  in  1  request to keep the grant on the next cycle.
- `sN_waitrequest`  out  1  low means the request is accepted this cycle.
- `sN_readdata`  out  32  read data.
- `sN_readdatavalid`  out  1  one-cycle pulse with `sN_readdata`.
- `ram_address`  out  15  to RAM.
- `ram_byteenable`  out  4  to RAM.
- `ram_chipselect`, `ram_write`  out  1  to RAM.
- `ram_writedata`  out  32  to RAM.
- `ram_clken`  out  1  constant 1.
- `ram_readdata`  in  32  from RAM; valid one cycle after the address.
- `err_count`  out  ERR_W  saturating count of out-of-range requests.

## Operation
- A port requests when `sN_read | sN_write`. The grant is combinational from current requests, FSM state and the registered `last` pointer (0 = port 0 won last).
- FSM states:
  - `ARB`: a single requester wins. If both request, the port != `last` wins.
  - `LOCKN`: entered when port N wins with `sN_lock` = 1. Only port N may win; the other port waits.
  - Leave `LOCKN` for `ARB` when `sN_lock` = 0 at an accepted transfer, when port N is idle for one cycle, or when `hold` reaches MAX_HOLD.
  - On forced release, `last` = N, so the other port wins any tie next.
- `hold` counter: loads 1 on entering `LOCKN` and increments per accepted transfer.
- Winner: its `sN_waitrequest` = 0. The loser's and any idle port's `sN_waitrequest` = 1. `last` updates to the winner in `ARB`.
- In-range winner: RAM signals are driven from the winner, with `ram_chipselect` = 1 and `ram_write` = `sN_write`.
- Out-of-range winner:
  - Accepted (waitrequest 0) but `ram_chipselect` = 0.
  - `err_count` increments, saturating at all-ones.
  - A read returns 0x00000000 with `readdatavalid`.
- Read return: a registered `rd_pend`/`rd_port`/`rd_oor` tag. At T+1, `sN_readdatavalid` pulses on the tagged port and `sN_readdata` = `ram_readdata`, or 0 if `rd_oor`. `readdata` of the non-tagged port is don't-care (driven 0).
- Throughput: one accepted transfer per cycle; back-to-back reads are allowed.

## Timing
- Reset values:
  - State `ARB`, `last` = 1 (port 0 wins the first tie), `hold` = 0.
  - `err_count` = 0; `sN_readdatavalid` = 0; `rd_pend` = 0.
  - `sN_waitrequest` follows the combinational rule; it is 1 while `reset` is high.
- Write: committed at the accept edge; no response.
- Read latency: exactly 1 cycle after accept.
- Simultaneous write from port 0 and read from port 1 at the same address: only the winner proceeds; the loser is served next cycle and sees the written data.
- Reset mid-burst: a pending `readdatavalid` is dropped and the lock is released.
- No combinational path from `ram_readdata` to any `waitrequest`.

## Structure
- Package `maoin_ram_pkg`: FSM state enum (`ARB`, `LOCK0`, `LOCK1`), `RAM_AW` = 15, `RAM_DW` = 32, `RAM_DEPTH` = 25000.
- Natural sub-module: `maoin_rr_grant`, a 2-way round-robin grant with lock/hold, keeping the datapath mux and read-return tag in the top.
- The top instantiates alongside the existing RAM; no RAM inside.

## Test plan
- Port 0 writes 0xCAFEF00D to 0x0010 with byteenable 0xF, then reads 0x0010 -> `s0_readdatavalid` one cycle after accept, data 0xCAFEF00D.
- Both ports read continuously, no lock -> grants alternate 0,1,0,1 starting with port 0 after reset; every read returns on the issuing port.
- Port 1 holds `s1_lock` with MAX_HOLD = 4 while port 0 requests -> port 1 gets 4 consecutive grants, then port 0 wins the next cycle.
- Port 0 reads 25000, then writes 0x7FFF -> both accepted, RAM chipselect stays 0, read data 0, `err_count` = 2; after 300 such requests `err_count` = 255.
- Byteenable 0x3 write of 0xFFFFFFFF over 0x12345678 -> readback 0x1234FFFF.
- Assert `reset` one cycle after a read accept -> no `readdatavalid`, `err_count` = 0, next tie granted to port 0.
